// File: rtl/data_mem_pkg.sv
// Shared constants and types for the data memory arbiter slice.
package data_mem_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 50;
    localparam int unsigned NPORTS = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef logic port_id_t;

    function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr);
        return addr >= ADDR_W'(DEPTH);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker; the pointer moves past the winner on each grant.
module rr_arbiter2
    import data_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       any_c,
    output port_id_t   win_c
);

    port_id_t ptr_q;

    always_comb begin
        any_c = |req;
        win_c = (req == 2'b11) ? ptr_q : port_id_t'(req[1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (accept && any_c) begin
            ptr_q <= ~win_c;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin sequencer in front of the single-port data memory.
// Optional address bounds check: DATA_MEM_ARB_BOUNDS_CHECK_EN.
module data_mem_arbiter
    import data_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    state_t            state_q, state_d;
    port_id_t          win_q, win_d;
    logic              we_q, we_d;
    logic              oob_q, oob_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic [DATA_W-1:0] rdata_q [NPORTS];
    logic [DATA_W-1:0] rdata_d [NPORTS];
    logic              mem_write_q, mem_write_d;
    logic              mem_read_q, mem_read_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;

    logic              any_c;
    port_id_t          win_c;
    logic              sel_we_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;
    logic              sel_oob_c;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({p1_req, p0_req}),
        .accept (state_q == ST_IDLE),
        .any_c  (any_c),
        .win_c  (win_c)
    );

    always_comb begin
        sel_we_c    = win_c ? p1_we    : p0_we;
        sel_addr_c  = win_c ? p1_addr  : p0_addr;
        sel_wdata_c = win_c ? p1_wdata : p0_wdata;
    end

`ifdef DATA_MEM_ARB_BOUNDS_CHECK_EN
    assign sel_oob_c = addr_out_of_range(sel_addr_c);
`else
    assign sel_oob_c = 1'b0;
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d       = state_q;
        win_d         = win_q;
        we_d          = we_q;
        oob_d         = oob_q;
        gnt_d         = '0;
        done_d        = '0;
        err_d         = '0;
        rdata_d       = rdata_q;
        mem_write_d   = 1'b0;
        mem_read_d    = 1'b0;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        case (state_q)
            ST_IDLE: begin
                if (any_c) begin
                    win_d         = win_c;
                    we_d          = sel_we_c;
                    oob_d         = sel_oob_c;
                    gnt_d[win_c]  = 1'b1;
                    mem_write_d   = sel_we_c & ~sel_oob_c;
                    mem_read_d    = ~sel_we_c & ~sel_oob_c;
                    mem_address_d = sel_addr_c;
                    mem_data_in_d = sel_wdata_c;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                // Registered memory read data is valid in this cycle.
                done_d[win_q] = 1'b1;
                err_d[win_q]  = oob_q;
                if (!we_q && !oob_q) begin
                    rdata_d[win_q] = mem_data_out;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            win_q         <= 1'b0;
            we_q          <= 1'b0;
            oob_q         <= 1'b0;
            gnt_q         <= '0;
            done_q        <= '0;
            err_q         <= '0;
            rdata_q[0]    <= '0;
            rdata_q[1]    <= '0;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            win_q         <= win_d;
            we_q          <= we_d;
            oob_q         <= oob_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            err_q         <= err_d;
            rdata_q[0]    <= rdata_d[0];
            rdata_q[1]    <= rdata_d[1];
            mem_write_q   <= mem_write_d;
            mem_read_q    <= mem_read_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
        end
    end

    assign p0_gnt      = gnt_q[0];
    assign p1_gnt      = gnt_q[1];
    assign p0_done     = done_q[0];
    assign p1_done     = done_q[1];
    assign p0_err      = err_q[0];
    assign p1_err      = err_q[1];
    assign p0_rdata    = rdata_q[0];
    assign p1_rdata    = rdata_q[1];
    assign mem_write   = mem_write_q;
    assign mem_read    = mem_read_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Two-port round-robin arbiter and sequencer in front of the single-port 50x8 data memory. Port 0 is the CPU load/store path; port 1 is the loader/debug path. The block serialises accesses, drives the memory's mem_write/mem_read/address/data_in for exactly one cycle per access, and accounts for the memory's one-cycle registered read latency. It returns read data with a one-cycle done pulse.

Parameters:
ADDR_W, 6, address width of each port and of the memory
DATA_W, 8, data width
DEPTH, 50, number of valid memory locations (addresses 0..DEPTH-1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
p0_req  input  1  port 0 access request; hold with p0_we/p0_addr/p0_wdata stable until p0_gnt
p0_we  input  1  port 0: 1=write, 0=read
p0_addr  input  ADDR_W  port 0 address
p0_wdata  input  DATA_W  port 0 write data
p0_gnt  output  1  port 0 request accepted, one-cycle pulse
p0_done  output  1  port 0 access complete, one-cycle pulse
p0_rdata  output  DATA_W  port 0 read data, valid with p0_done, held until next p0 read done
p0_err  output  1  port 0 out-of-range access, valid with p0_done
p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_done, p1_rdata, p1_err: identical for port 1
mem_write  output  1  to memory write enable
mem_read  output  1  to memory read enable
mem_address  output  ADDR_W  to memory address
mem_data_in  output  DATA_W  to memory write data
mem_data_out  input  DATA_W  from memory registered read data

Behaviour:
- Reset (rst_n low, async): state IDLE; rr pointer favours port 0; all outputs 0, including rdata.
- FSM states IDLE, ISSUE, RESP. All outputs are registered.
- IDLE: no req stays in IDLE. Any req: pick the winner and latch winner id, we, addr and wdata. Set gnt[winner] for the next cycle and go to ISSUE.
- Arbitration: one requester wins outright. When both request, the rr pointer decides. The pointer moves to the other port after each grant.
- ISSUE: gnt pulse high. mem_write = latched we, mem_read = !we, with mem_address and mem_data_in driven from the latches. The memory samples at the end of this cycle. Next state is RESP.
- RESP: all mem_* commands 0 (mem_address/mem_data_in hold). mem_data_out is valid in this cycle. At the closing edge, rdata[winner] <= mem_data_out for reads only, and done[winner] <= 1. Next state is IDLE.
- done is high for exactly the one IDLE cycle after RESP. A new arbitration may be decided in that same cycle.
- Latency: request sampled in IDLE (cycle 0), gnt in cycle 1, memory access at end of cycle 1, done in cycle 3. Throughput is one access per 3 cycles; there is no pipelining.
- The requester must drop req or change the request the cycle after gnt. A req still high after gnt is a new request.
- The non-winning port's req is ignored until the next IDLE. It is never lost.
- Reset mid-operation: the command deasserts immediately. The in-flight access may or may not reach memory. No done is produced.

Optional Feature:
DATA_MEM_ARB_BOUNDS_CHECK_EN.
- Defined: in IDLE, an address >= DEPTH is flagged. The ISSUE cycle runs with mem_write=mem_read=0. done and err are asserted together, and rdata is left unchanged.
- Undefined: no check is made. The address passes to memory unmodified, and err is tied 0.

Decomposition:
- Shared package data_mem_pkg: ADDR_W, DATA_W, DEPTH constants; FSM state enum (IDLE/ISSUE/RESP, 2 bits); port-id type.
- Sub-module rr_arbiter2: 2-requester round-robin picker with pointer update on grant. Everything else stays in the top.

Test Plan:
- Port 0 writes 0xA5 at addr 7, then reads addr 7 -> p0_gnt in cycle 1, mem_write high for exactly 1 cycle, p0_done in cycle 3; read returns p0_rdata=0xA5.
- p0 and p1 request continuously from reset (p0 reads addr 3, p1 writes 0x3C at addr 3) -> grants alternate p0,p1,p0,...; first p0 read returns 0x00, later reads return 0x3C.
- p1 writes 0x11 at addr 49, then reads it -> 0x11 returned. mem_read and mem_write are never high together.
- rst_n pulled low during ISSUE of a p0 write -> all outputs 0 asynchronously, no p0_done, state IDLE, next grant goes to p0.
- With DATA_MEM_ARB_BOUNDS_CHECK_EN, p0 reads addr 55 -> no mem_read, p0_done=p0_err=1 in cycle 3, p0_rdata unchanged.
- Without the macro, the same access -> mem_read high for 1 cycle with mem_address=55, and p0_err=0.
